// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared constants and types for the SPI register controller.
//   - frame field widths and default frame length
//   - register address map
//   - frame FSM state encoding
package spi_reg_pkg;

  localparam int FRAME_BITS_DEF = 16;
  localparam int ADDR_W         = 7;
  localparam int DATA_W         = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

endpackage

// File: rtl/spi_reg_ctrl_sync_edge.sv
// sync_edge: STAGES-flop synchronizer with edge detect.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input pin
//   level    : synchronized level
//   rise     : one-cycle strobe on a 0->1 of the synchronized level
//   fall     : one-cycle strobe on a 1->0 of the synchronized level
// RST_VAL is the idle level of the pin, so leaving reset never fakes an edge.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  =  level & ~prev_q;
  assign fall  = ~level &  prev_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI (mode 0, MSB first) write-only configuration port for
// the PWM datapath. A frame is {rw, addr[6:0], data[7:0]}; valid writes land
// in a small register bank.
//   clk, rst     : system clock, synchronous active-high reset
//   sclk/ncs/copi: raw SPI pins, asynchronous to clk
//   en_out       : output enables {reg 0x01, reg 0x00}
//   en_pwm       : PWM enables    {reg 0x03, reg 0x02}
//   duty         : PWM duty, reg 0x04
//   commit_pulse : one-cycle strobe when a register is written
//   frame_err    : one-cycle strobe on a frame of the wrong length
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        ncs,
  input  logic        copi,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm,
  output logic [7:0]  duty,
  output logic        commit_pulse,
  output logic        frame_err
);

  // Counter must reach FRAME_BITS+1 so over-long frames stay distinguishable.
  localparam int                CNT_W      = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(FRAME_BITS + 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_lvl, sclk_rise, sclk_fall_unused;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi),
    .level(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    pend_q, pend_d;
  logic                    wr_en;

  logic                    frame_rw;
  logic [ADDR_W-1:0]       frame_addr;
  logic [DATA_W-1:0]       frame_data;

  assign frame_rw   = shift_q[FRAME_BITS-1];
  assign frame_addr = shift_q[FRAME_BITS-2 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    pend_d       = pend_q;
    wr_en        = 1'b0;
    commit_pulse = 1'b0;
    frame_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // pend_q covers an ncs fall that arrived while in COMMIT.
        if (ncs_fall || pend_q) begin
          cnt_d   = '0;
          shift_d = '0;
          pend_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // ncs rise wins over a same-sample sclk rise; that bit is dropped.
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise && !ncs_lvl) begin
          shift_d = {shift_q[FRAME_BITS-2:0], copi_lvl};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (ncs_fall) pend_d = 1'b1;
        if (cnt_q == CNT_FULL) begin
          // Reads and out-of-range addresses are dropped silently.
          if (frame_rw && ({1'b0, frame_addr} < ADDR_LIMIT)) begin
            wr_en        = 1'b1;
            commit_pulse = 1'b1;
          end
        end else begin
          frame_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [DATA_W-1:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_lo <= '0;
      en_out_hi <= '0;
      en_pwm_lo <= '0;
      en_pwm_hi <= '0;
      duty_q    <= '0;
    end else if (wr_en) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: en_out_lo <= frame_data;
        ADDR_EN_OUT_HI: en_out_hi <= frame_data;
        ADDR_EN_PWM_LO: en_pwm_lo <= frame_data;
        ADDR_EN_PWM_HI: en_pwm_hi <= frame_data;
        ADDR_DUTY:      duty_q    <= frame_data;
        default: ;
      endcase
    end
  end

  assign en_out = {en_out_hi, en_out_lo};
  assign en_pwm = {en_pwm_hi, en_pwm_lo};
  assign duty   = duty_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, ncs, copi;
  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;
  logic        commit_pulse, frame_err;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cp_cnt   = 0;
  int fe_cnt   = 0;

  spi_reg_ctrl #(.NUM_REGS(5), .SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .en_out(en_out), .en_pwm(en_pwm), .duty(duty),
    .commit_pulse(commit_pulse), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // High-cycle counters: a single frame must add exactly one to cp_cnt.
  always @(negedge clk) begin
    if (commit_pulse === 1'b1) cp_cnt++;
    if (frame_err === 1'b1)    fe_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sclk = clk/8: 4 cycles low, 4 cycles high per bit.
  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(v, n);
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(12);
  endtask

  task automatic test_reset;
    int cp0, fe0;
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(1);
    vec_cnt++;
    if ({en_out, en_pwm, duty, commit_pulse, frame_err} !== 42'd0) begin
      miss_cnt++;
      $display("FAIL reset_outputs: got %h, want 0", {en_out, en_pwm, duty, commit_pulse, frame_err});
    end
    cp0 = cp_cnt; fe0 = fe_cnt;
    wait_clk(100);
    vec_cnt++;
    if ((cp_cnt - cp0) !== 0 || (fe_cnt - fe0) !== 0) begin
      miss_cnt++;
      $display("FAIL idle_strobes: commits %0d errs %0d, want 0 0", cp_cnt - cp0, fe_cnt - fe0);
    end
    // Reset lands after 8 bits of a frame; the partial frame must vanish.
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(32'h80, 8);
    rst = 1'b1;
    wait_clk(2);
    ncs = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    cp0 = cp_cnt; fe0 = fe_cnt;
    send_frame(32'h8033, 16);
    vec_cnt++;
    if (en_out !== 16'h0033) begin
      miss_cnt++;
      $display("FAIL reset_midframe_en_out: got %h, want 0033", en_out);
    end
    vec_cnt++;
    if ((cp_cnt - cp0) !== 1 || (fe_cnt - fe0) !== 0) begin
      miss_cnt++;
      $display("FAIL reset_midframe_strobes: commits %0d errs %0d, want 1 0", cp_cnt - cp0, fe_cnt - fe0);
    end
  endtask

  task automatic test_write;
    int cp0;
    cp0 = cp_cnt;
    send_frame(32'h80F0, 16);
    vec_cnt++;
    if (en_out !== 16'h00F0) begin
      miss_cnt++;
      $display("FAIL write_lo: got %h, want 00f0", en_out);
    end
    vec_cnt++;
    if ((cp_cnt - cp0) !== 1) begin
      miss_cnt++;
      $display("FAIL write_lo_pulse_cycles: got %0d, want 1", cp_cnt - cp0);
    end
    send_frame(32'h8155, 16);
    vec_cnt++;
    if (en_out !== 16'h55F0) begin
      miss_cnt++;
      $display("FAIL write_hi: got %h, want 55f0", en_out);
    end
  endtask

  // Duty write with cycle-exact latency, then dropped read / bad address.
  task automatic test_duty_and_drop;
    int cp0, fe0;
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(32'h8480, 16);
    wait_clk(4);
    ncs = 1'b1;           // pin rise just after a negedge
    wait_clk(3);          // 3 posedges: sync(2) + edge-detect -> COMMIT
    vec_cnt++;
    if (duty !== 8'h00 || commit_pulse !== 1'b1) begin
      miss_cnt++;
      $display("FAIL duty_commit_cycle: duty %h pulse %b, want 00 1", duty, commit_pulse);
    end
    wait_clk(1);
    vec_cnt++;
    if (duty !== 8'h80 || commit_pulse !== 1'b0) begin
      miss_cnt++;
      $display("FAIL duty_latency: duty %h pulse %b, want 80 0", duty, commit_pulse);
    end
    wait_clk(8);
    cp0 = cp_cnt; fe0 = fe_cnt;
    send_frame(32'h0400, 16);
    send_frame(32'h8A11, 16);
    vec_cnt++;
    if (duty !== 8'h80 || en_out !== 16'h55F0 || en_pwm !== 16'h0000) begin
      miss_cnt++;
      $display("FAIL drop_regs: duty %h en_out %h en_pwm %h, want 80 55f0 0000", duty, en_out, en_pwm);
    end
    vec_cnt++;
    if ((cp_cnt - cp0) !== 0 || (fe_cnt - fe0) !== 0) begin
      miss_cnt++;
      $display("FAIL drop_strobes: commits %0d errs %0d, want 0 0", cp_cnt - cp0, fe_cnt - fe0);
    end
  endtask

  task automatic test_bad_length;
    int cp0, fe0;
    cp0 = cp_cnt; fe0 = fe_cnt;
    send_frame(32'h82FF >> 1, 15);
    vec_cnt++;
    if ((fe_cnt - fe0) !== 1) begin
      miss_cnt++;
      $display("FAIL short_frame_err: got %0d, want 1", fe_cnt - fe0);
    end
    send_frame({15'd0, 16'h82FF, 1'b0}, 17);
    vec_cnt++;
    if ((fe_cnt - fe0) !== 2) begin
      miss_cnt++;
      $display("FAIL long_frame_err: got %0d, want 2", fe_cnt - fe0);
    end
    send_frame(32'h0, 0);
    vec_cnt++;
    if ((fe_cnt - fe0) !== 3) begin
      miss_cnt++;
      $display("FAIL empty_frame_err: got %0d, want 3", fe_cnt - fe0);
    end
    vec_cnt++;
    if (en_pwm !== 16'h0000 || (cp_cnt - cp0) !== 0) begin
      miss_cnt++;
      $display("FAIL bad_length_regs: en_pwm %h commits %0d, want 0000 0", en_pwm, cp_cnt - cp0);
    end
  endtask

  task automatic test_back_to_back;
    int cp0, fe0;
    cp0 = cp_cnt; fe0 = fe_cnt;
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(32'h8201, 16);
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(16);         // two sclk periods of deselect
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(32'h8302, 16);
    wait_clk(4);
    ncs = 1'b1;
    wait_clk(12);
    vec_cnt++;
    if (en_pwm !== 16'h0201) begin
      miss_cnt++;
      $display("FAIL b2b_en_pwm: got %h, want 0201", en_pwm);
    end
    vec_cnt++;
    if ((cp_cnt - cp0) !== 2 || (fe_cnt - fe0) !== 0) begin
      miss_cnt++;
      $display("FAIL b2b_strobes: commits %0d errs %0d, want 2 0", cp_cnt - cp0, fe_cnt - fe0);
    end
  endtask

  task automatic test_idle_and_coincident;
    int cp0, fe0;
    cp0 = cp_cnt; fe0 = fe_cnt;
    copi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(8);
    vec_cnt++;
    if ((cp_cnt - cp0) !== 0 || (fe_cnt - fe0) !== 0 || en_pwm !== 16'h0201) begin
      miss_cnt++;
      $display("FAIL idle_sclk: commits %0d errs %0d en_pwm %h, want 0 0 0201",
               cp_cnt - cp0, fe_cnt - fe0, en_pwm);
    end
    // 16th sclk rise and ncs rise in the same sample: bit 16 is dropped.
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(32'h82FF >> 1, 15);
    copi = 1'b1;
    wait_clk(4);
    sclk = 1'b1;
    ncs  = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
    wait_clk(12);
    vec_cnt++;
    if ((fe_cnt - fe0) !== 1 || (cp_cnt - cp0) !== 0) begin
      miss_cnt++;
      $display("FAIL coincident_strobes: errs %0d commits %0d, want 1 0", fe_cnt - fe0, cp_cnt - cp0);
    end
    vec_cnt++;
    if (en_pwm !== 16'h0201) begin
      miss_cnt++;
      $display("FAIL coincident_en_pwm: got %h, want 0201", en_pwm);
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_duty_and_drop;
    test_bad_length;
    test_back_to_back;
    test_idle_and_coincident;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
SPI peripheral-side configuration controller for the PWM output datapath of the onboarding project.
- Receives 16-bit write frames from an external SPI controller and decodes them.
- Commits data into a small register bank of output enables, PWM enables and duty cycle, which drives the PWM block and uo_out/uio_out.
- Sits between the raw ui_in pins and the PWM generator. It is the only writer of PWM configuration.

Parameters:
NUM_REGS, 5, number of implemented addresses (0x00..NUM_REGS-1); other addresses ignored
SYNC_STAGES, 2, flops per input synchronizer (min 2)
FRAME_BITS, 16, required frame length in bits

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
sclk  input  1  SPI clock, asynchronous to clk
ncs  input  1  SPI chip select, active low, asynchronous
copi  input  1  SPI data in, asynchronous
en_out  output  16  output enables: [7:0] = reg 0x00, [15:8] = reg 0x01
en_pwm  output  16  PWM enables: [7:0] = reg 0x02, [15:8] = reg 0x03
duty  output  8  PWM duty cycle, reg 0x04
commit_pulse  output  1  one-cycle strobe when a register is written
frame_err  output  1  one-cycle strobe on a malformed frame

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high on rst.
- Reset: all registers 0x00, so en_out = 0, en_pwm = 0, duty = 0. commit_pulse = 0, frame_err = 0, state = IDLE, bit count = 0, shift register = 0.
  - Reset overrides any frame in progress; that partial frame is discarded.
  - Synchronizers are reset to idle levels: sclk = 0, ncs = 1, copi = 0.
- Input conditioning:
  - sclk, ncs and copi each pass through SYNC_STAGES flops.
  - Rise/fall detection on synced sclk and ncs compares the last synced value with the previous one.
  - Supported sclk frequency is at most clk/8.
- SPI mode 0, MSB first. copi is sampled on a synced sclk rising edge only while synced ncs = 0.
- Frame format:
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
- FSM:
  - IDLE: wait for the ncs falling edge. On it, clear bit count and shift register, then go to SHIFT. sclk edges in IDLE are ignored.
  - SHIFT: on each sclk rise, shift register <= {shift[14:0], copi} and increment bit count. The counter saturates at FRAME_BITS+1. On the ncs rising edge, go to COMMIT.
  - COMMIT (exactly one cycle), then IDLE:
    - If bit count == 16, R/W = 1 and address < NUM_REGS: write the addressed register and assert commit_pulse in the same cycle. Outputs reflect the new value on the next cycle.
    - If bit count == 16 and (R/W = 0 or address >= NUM_REGS): no update, no strobe. Reads are silently dropped.
    - If bit count != 16 (short, long or zero-length frame): no update, assert frame_err.
- Simultaneous ncs rise and sclk rise in the same synced sample: ncs takes priority and that sclk edge is discarded.
- An ncs fall while in COMMIT is not lost. COMMIT is one cycle and the synced ncs level is still low on return to IDLE, so a pending-start flag latched in COMMIT makes IDLE move directly to SHIFT.
- Latency: the register updates SYNC_STAGES+2 clk cycles after the pin-level ncs rise.
- Registers hold their value indefinitely between writes. Writing the same value still pulses commit_pulse.

Decomposition:
- Package spi_reg_pkg holds:
  - address constants ADDR_EN_OUT_LO = 0x00, ADDR_EN_OUT_HI = 0x01, ADDR_EN_PWM_LO = 0x02, ADDR_EN_PWM_HI = 0x03, ADDR_DUTY = 0x04;
  - the FRAME_BITS default and the field widths (ADDR_W = 7, DATA_W = 8);
  - the FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module sync_edge: SYNC_STAGES-flop synchronizer with rise/fall outputs and a reset value parameter. It is instantiated three times (sclk, ncs, copi; copi uses only the level output).
- The register bank and FSM stay in spi_reg_ctrl.

Test Plan:
- Reset, then idle pins -> all outputs 0, no strobes over 100 cycles. Asserting rst mid-frame after 8 bits, then releasing, then a full valid frame -> only the second frame commits.
- Write 0x80F0 (addr 0x00, data 0xF0) -> en_out = 0x00F0, commit_pulse high exactly 1 cycle. Then write 0x8155 -> en_out = 0x55F0.
- Write 0x8480 -> duty = 0x80. Then write 0x0400 (read) and 0x8A11 (addr 0x0A) -> duty remains 0x80, en_* unchanged, no commit_pulse, no frame_err.
- Frames of 15 bits and 17 bits carrying 0x82FF -> frame_err pulses once each, en_pwm stays 0x0000. ncs low/high with no sclk -> frame_err.
- Back-to-back frames 0x8201 and 0x8302 with ncs high for only 2 sclk periods, at sclk = clk/8 -> en_pwm = 0x0201, two commit_pulses.
- sclk toggling with ncs high, plus an ncs rise coincident with the 16th sclk rise -> idle toggles ignored; the coincident frame counts 15 bits and raises frame_err.
